// File: rtl/mac_result_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Fixed-point constants, status bit map and bias/sat/ReLU helper
//               shared by the MAC result drain path.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int FXP_W = 16;

    typedef logic signed [FXP_W-1:0] fxp_t;

    localparam fxp_t FXP_MAX = 16'sh7FFF;
    localparam fxp_t FXP_MIN = 16'sh8000;

    localparam int ST_SAT   = 0;
    localparam int ST_DROP  = 1;
    localparam int ST_PROTO = 2;
    localparam int ST_W     = 3;

    typedef struct packed {
        logic [FXP_W-1:0] value;
        logic             sat;
    } fxp_res_t;

    // Saturate first, then ReLU, so a clamped negative still reports sat.
    function automatic fxp_res_t bias_sat_relu(input fxp_t d, input fxp_t b, input logic relu);
        logic signed [FXP_W:0] sum;
        fxp_res_t              res;
        sum = {d[FXP_W-1], d} + {b[FXP_W-1], b};
        res.sat = 1'b0;
        if (sum[FXP_W:FXP_W-1] == 2'b01) begin
            res.value = FXP_MAX;
            res.sat   = 1'b1;
        end else if (sum[FXP_W:FXP_W-1] == 2'b10) begin
            res.value = FXP_MIN;
            res.sat   = 1'b1;
        end else begin
            res.value = sum[FXP_W-1:0];
        end
        if (relu && res.value[FXP_W-1]) begin
            res.value = '0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_drain_if
// Description : MAC result input, credit handshake and ready/valid drain bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_result_drain_if;
    import mac_pkg::*;

    logic [FXP_W-1:0] in_data;
    logic             in_valid;
    logic             issue;
    logic             credit_ok;
    logic [FXP_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, issue, out_ready,
        input  credit_ok, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, issue, out_ready,
        output credit_ok, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mac_result_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : First-word-fall-through synchronous FIFO, async active-high
//               reset, occupancy counter distinguishes full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic      [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop  = rd_en && !empty;
    assign w_push = wr_en && (!full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_drain
// Description : Bias/saturate/ReLU post-processing of MAC results, credit
//               reservation for the sequencer, FWFT result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mac_result_drain_if.slave      bus,
    input  wire logic [FXP_W-1:0]  bias,
    input  wire logic              relu_en,
    output logic      [CW-1:0]     count,
    output logic      [ST_W-1:0]   status,
    input  wire logic              clear_sticky
);
    fxp_res_t         w_proc;
    logic             w_push_req;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic [FXP_W-1:0] w_rd_data;
    logic [CW:0]      w_occupied;
    logic             w_credit_ok;
    logic [ST_W-1:0]  w_set;
    logic [CW-1:0]    r_reserved;
    logic [ST_W-1:0]  r_status;

    assign w_proc     = bias_sat_relu(bus.in_data, bias, relu_en);
    assign w_push_req = bus.in_valid;
    assign w_pop      = bus.out_ready && !w_empty;
    assign w_accept   = w_push_req && (!w_full || w_pop);

    sync_fifo_fwft #(
        .WIDTH (FXP_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push_req),
        .wr_data (w_proc.value),
        .rd_en   (bus.out_ready),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .full    (w_full),
        .count   (count)
    );

    assign bus.out_data  = w_rd_data;
    assign bus.out_valid = !w_empty;

    // Reserved slots count as occupied so in-flight MAC results always fit.
    assign w_occupied  = {1'b0, count} + {1'b0, r_reserved};
    assign w_credit_ok = (w_occupied < (CW + 1)'(DEPTH));
    assign bus.credit_ok = w_credit_ok;

    always_comb begin
        w_set           = '0;
        w_set[ST_SAT]   = bus.in_valid && w_proc.sat;
        w_set[ST_DROP]  = w_push_req && !w_accept;
        w_set[ST_PROTO] = (bus.issue && !w_credit_ok)
                       || (bus.in_valid && !bus.issue && (r_reserved == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reserved <= '0;
            r_status   <= '0;
        end else begin
            if (bus.issue && !bus.in_valid) begin
                if (r_reserved != CW'(DEPTH)) begin
                    r_reserved <= r_reserved + CW'(1);
                end
            end else if (bus.in_valid && !bus.issue) begin
                if (r_reserved != '0) begin
                    r_reserved <= r_reserved - CW'(1);
                end
            end
            // New events win over a simultaneous clear.
            r_status <= (clear_sticky ? '0 : r_status) | w_set;
        end
    end

    assign status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_result_drain
// Description : Scoreboard bench for mac_result_drain (DEPTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_result_drain;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [15:0]   bias;
    logic          relu_en;
    logic          clear_sticky;
    logic [CW-1:0] count;
    logic [2:0]    status;

    mac_result_drain_if bus ();

    mac_result_drain #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .bias         (bias),
        .relu_en      (relu_en),
        .count        (count),
        .status       (status),
        .clear_sticky (clear_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] sb[$];
    int          res_m = 0;
    logic [2:0]  st_m  = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arithmetic in plain integers: returns {sat, value}.
    function automatic logic [16:0] ref_proc(input logic [15:0] d, input logic [15:0] b, input logic relu);
        int          s;
        logic [15:0] r;
        logic        sat;
        s   = int'($signed(d)) + int'($signed(b));
        sat = 1'b0;
        if (s > 32767) begin
            r = 16'h7FFF; sat = 1'b1;
        end else if (s < -32768) begin
            r = 16'h8000; sat = 1'b1;
        end else begin
            r = s[15:0];
        end
        if (relu && (s < 0)) r = 16'h0000;
        return {sat, r};
    endfunction

    function automatic logic credit_m();
        return (sb.size() + res_m) < DEPTH;
    endfunction

    // One clock: drive, check DUT against the model at negedge, update model.
    task automatic step(input logic v, input logic [15:0] d, input logic is,
                        input logic rdy, input logic clr);
        logic [16:0] p;
        logic [2:0]  set;
        logic        cr;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.issue     = is;
        bus.out_ready = rdy;
        clear_sticky  = clr;
        @(negedge clk);
        cr = credit_m();
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) check("out_data", 32'(bus.out_data), 32'(sb[0]));
        check("count", 32'(count), 32'(sb.size()));
        check("count_le_depth", 32'(count <= DEPTH), 32'd1);
        check("credit_ok", 32'(bus.credit_ok), 32'(cr));
        check("status", 32'(status), 32'(st_m));
        set = 3'b000;
        if (rdy && sb.size() != 0) void'(sb.pop_front());
        if (v) begin
            p = ref_proc(d, bias, relu_en);
            if (p[16]) set[0] = 1'b1;
            if (sb.size() < DEPTH) sb.push_back(p[15:0]);
            else set[1] = 1'b1;
        end
        if (is && !cr) set[2] = 1'b1;
        if (v && !is && res_m == 0) set[2] = 1'b1;
        if (is && !v) res_m = (res_m < DEPTH) ? res_m + 1 : DEPTH;
        else if (v && !is && res_m > 0) res_m = res_m - 1;
        st_m = (clr ? 3'b000 : st_m) | set;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0000, 1'b0, rdy, 1'b0);
    endtask

    task automatic send(input logic [15:0] d);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && sb.size() != 0; i++) idle(1'b1);
        check("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int sent;
        int issued;
        int cyc;
        rst = 1'b1;
        bias = 16'h0000;
        relu_en = 1'b0;
        clear_sticky = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 16'h0000;
        bus.issue = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_credit_ok", 32'(bus.credit_ok), 32'd1);
        check("rst_status", 32'(status), 32'd0);
        rst = 1'b0;

        // Bias add
        bias = 16'h0100;
        send(16'h0200);
        check("bias_add_data", 32'(bus.out_data), 32'h0300);
        check("bias_add_valid", 32'(bus.out_valid), 32'd1);
        check("bias_add_status", 32'(status), 32'd0);
        drain();

        // Saturation and ReLU
        bias = 16'h0200;
        send(16'h7F00);
        check("sat_pos_data", 32'(bus.out_data), 32'h7FFF);
        check("sat_pos_flag", 32'(status[0]), 32'd1);
        drain();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        bias = 16'hFE00;
        send(16'h8100);
        check("sat_neg_data", 32'(bus.out_data), 32'h8000);
        drain();
        relu_en = 1'b1;
        send(16'h8100);
        check("sat_relu_data", 32'(bus.out_data), 32'h0000);
        drain();
        relu_en = 1'b0;
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Credits with the consumer stalled
        bias = 16'h0000;
        repeat (5) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 1'b0);
        check("credit_count3", 32'(count), 32'd3);
        check("credit_ok_res2", 32'(bus.credit_ok), 32'd1);
        repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("credit_exhausted", 32'(bus.credit_ok), 32'd0);
        check("no_proto_yet", 32'(status[2]), 32'd0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("proto_9th_issue", 32'(status[2]), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0020 + i), 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd8);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Full: push with same-cycle pop, then push without pop
        step(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0);
        check("full_pop_count", 32'(count), 32'd8);
        check("full_pop_nodrop", 32'(status[1]), 32'd0);
        send(16'h0066);
        check("full_drop_count", 32'(count), 32'd8);
        check("full_drop_flag", 32'(status[1]), 32'd1);
        drain();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Ordering under random backpressure
        bias = 16'h0123;
        sent = 0;
        issued = 0;
        cyc = 0;
        while (sent < 200 && cyc < 5000) begin
            logic is;
            logic v;
            is = (issued < 200) && credit_m() && ($urandom_range(0, 1) == 1);
            v  = (res_m > 0) && ($urandom_range(0, 2) != 0);
            step(v, 16'($urandom), is, 1'($urandom_range(0, 1)), 1'b0);
            if (is) issued++;
            if (v) sent++;
            cyc++;
        end
        check("random_all_sent", 32'(sent), 32'd200);
        drain();

        // Asynchronous reset with count = 4, reserved = 2
        bias = 16'h0200;
        repeat (6) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h7F00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd4);
        check("pre_rst_credit", 32'(bus.credit_ok), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_data", 32'(bus.out_data), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_credit_ok", 32'(bus.credit_ok), 32'd1);
        check("arst_status", 32'(status), 32'd0);
        sb.delete();
        res_m = 0;
        st_m = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sat event beats a same-cycle clear
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h7F00, 1'b0, 1'b0, 1'b1);
        check("sat_beats_clear", 32'(status[0]), 32'd1);
        drain();
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
